// File: rtl/bottomhalf_cmd_engine.sv
// bottomhalf_cmd_engine
//   Queued command sequencer with a programmable microsecond delay, running in
//   the oscillator domain. Host writes push {cmd, arg} pairs into a FIFO. The
//   engine hands them one at a time to chip-specific payload logic. The payload
//   steps cmd_state and times its actions with the delay counter.
//
// Ports
//   osc, rst                   clock, asynchronous active-high reset
//   wr_stb, wr_cmd, wr_arg     push request (already synchronised to osc)
//   fifo_full, fifo_level      queue status (level excludes the active command)
//   cmd_valid, cmd_start       active command present / first cycle pulse
//   cmd_nr, cmd_arg, cmd_state active command number, argument, state
//   cmd_step                   payload may act (command active, no delay running)
//   state_set, state_value     load a new cmd_state
//   cmd_finish                 retire the active command
//   delay_start, delay_usec    start a delay of delay_usec microseconds
//   delay_busy                 delay in progress
//   err_overflow, err_clr      sticky dropped-push flag and its clear
//   status                     registered summary byte, one cycle behind
//
// Engine states
//   state   | meaning
//   ST_IDLE | no active command; the next queued entry is dispatched
//   ST_RUN  | a command is active; a finish retires it or chains the next one

module bottomhalf_cmd_engine #(
   parameter int CLK_MHZ = 24,
   parameter int USEC_W  = 12,
   // 17 bits is the smallest width that holds 24*4095-1
   parameter int CNT_W   = 17,
   parameter int CMD_W   = 4,
   parameter int STATE_W = 4,
   parameter int DEPTH   = 4
) (
   input  logic                       osc,
   input  logic                       rst,
   input  logic                       wr_stb,
   input  logic [CMD_W-1:0]           wr_cmd,
   input  logic [7:0]                 wr_arg,
   output logic                       fifo_full,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       cmd_valid,
   output logic                       cmd_start,
   output logic [CMD_W-1:0]           cmd_nr,
   output logic [7:0]                 cmd_arg,
   output logic [STATE_W-1:0]         cmd_state,
   output logic                       cmd_step,
   input  logic                       state_set,
   input  logic [STATE_W-1:0]         state_value,
   input  logic                       cmd_finish,
   input  logic                       delay_start,
   input  logic [USEC_W-1:0]          delay_usec,
   output logic                       delay_busy,
   output logic                       err_overflow,
   input  logic                       err_clr,
   output logic [7:0]                 status
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [63:0] MAX_LOAD =
      64'(CLK_MHZ) * ((64'd1 << USEC_W) - 64'd1) - 64'd1;

   generate
      if (MAX_LOAD >= (64'd1 << CNT_W)) begin : g_cnt_w_chk
         $error("CNT_W too narrow for CLK_MHZ*(2^USEC_W-1)-1");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
         $error("DEPTH must be a power of two >= 2");
      end
   endgenerate

   typedef enum logic {ST_IDLE, ST_RUN} eng_state_t;

   eng_state_t           state, state_nxt;
   logic [CMD_W+7:0]     mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CMD_W+7:0]     head;
   logic                 pop, push, overflow, finish_act;
   logic [CNT_W-1:0]     delay_cnt, delay_load;
   logic [3:0]           status_lvl;

   assign fifo_full  = (fifo_level == LW'(DEPTH));
   assign cmd_valid  = (state == ST_RUN);
   assign finish_act = cmd_valid & cmd_finish;
   // A finishing command frees the slot in the same cycle, so the next entry
   // is dispatched back-to-back without an idle gap.
   assign pop        = (fifo_level != '0) & (~cmd_valid | cmd_finish);
   // A pop in the same cycle makes room for a push even when full.
   assign push       = wr_stb & (~fifo_full | pop);
   assign overflow   = wr_stb & fifo_full & ~pop;
   assign head       = mem[rd_ptr];
   assign cmd_step   = cmd_valid & ~delay_busy;
   assign delay_load = CNT_W'(CLK_MHZ) * CNT_W'(delay_usec) - CNT_W'(1);
   assign status_lvl = 4'(fifo_level);

   // FIFO storage needs no reset; the pointers define what is valid.
   always_ff @(posedge osc) begin
      if (push) mem[wr_ptr] <= {wr_cmd, wr_arg};
   end

   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge osc or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (pop) state_nxt = ST_RUN;
         ST_RUN:  if (cmd_finish && !pop) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A finish always beats a simultaneous state_set: the retiring command's
   // state is meaningless and a chained command must start at state 0.
   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         cmd_start <= 1'b0;
         cmd_nr    <= '0;
         cmd_arg   <= '0;
         cmd_state <= '0;
      end else begin
         cmd_start <= pop;
         if (pop) begin
            cmd_nr    <= head[CMD_W+7:8];
            cmd_arg   <= head[7:0];
            cmd_state <= '0;
         end else if (finish_act) begin
            cmd_state <= '0;
         end else if (state_set && cmd_valid) begin
            cmd_state <= state_value;
         end
      end
   end

   // Down-counter loaded with N-1; busy drops the cycle after it reaches
   // zero, giving exactly N busy cycles.
   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         delay_cnt  <= '0;
         delay_busy <= 1'b0;
      end else if (finish_act) begin
         delay_cnt  <= '0;
         delay_busy <= 1'b0;
      end else if (delay_start && delay_usec != '0) begin
         delay_cnt  <= delay_load;
         delay_busy <= 1'b1;
      end else if (delay_busy) begin
         if (delay_cnt == '0) delay_busy <= 1'b0;
         else                 delay_cnt  <= delay_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         err_overflow <= 1'b0;
         status       <= '0;
      end else begin
         if (overflow)     err_overflow <= 1'b1;
         else if (err_clr) err_overflow <= 1'b0;
         status <= {err_overflow, delay_busy, cmd_valid, fifo_full, status_lvl};
      end
   end

endmodule
